// File: rtl/control_sequencer.sv
// SAW-BR control sequencer: six-state T-ring plus HALT, decoding the IR opcode into the control word.
// Optional JMP opcode (0011) is enabled by defining SAW_JMP_EN.
module control_sequencer (
  input  logic       clock,
  input  logic       clear,
  input  logic [3:0] instruction,
  output logic       pc_inc,
  output logic       pc_out,
  output logic       pc_load,
  output logic       mar_in,
  output logic       ram_out,
  output logic       ir_in,
  output logic       ir_out,
  output logic       acc_in,
  output logic       acc_out,
  output logic       b_in,
  output logic       alu_out,
  output logic       sub,
  output logic       out_in,
  output logic       halted,
  output logic [5:0] t_state
);

  typedef enum logic [2:0] {
    T1   = 3'd0,
    T2   = 3'd1,
    T3   = 3'd2,
    T4   = 3'd3,
    T5   = 3'd4,
    T6   = 3'd5,
    HALT = 3'd6
  } state_t;

  state_t state, next_state;

  // State register: clear forces T1 immediately.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= T1;
    end else begin
      state <= next_state;
    end
  end

  // Next-state ring; HLT leaves the ring at the end of T4.
  always_comb begin
    next_state = state;
    case (state)
      T1:      next_state = T2;
      T2:      next_state = T3;
      T3:      next_state = T4;
      T4:      next_state = (instruction == 4'b1111) ? HALT : T5;
      T5:      next_state = T6;
      T6:      next_state = T1;
      HALT:    next_state = HALT;
      default: next_state = T1;
    endcase
  end

  // Control word decode, gated by clear so no pulse survives an asynchronous abort.
  always_comb begin
    pc_inc  = 1'b0;
    pc_out  = 1'b0;
    pc_load = 1'b0;
    mar_in  = 1'b0;
    ram_out = 1'b0;
    ir_in   = 1'b0;
    ir_out  = 1'b0;
    acc_in  = 1'b0;
    acc_out = 1'b0;
    b_in    = 1'b0;
    alu_out = 1'b0;
    sub     = 1'b0;
    out_in  = 1'b0;
    halted  = 1'b0;
    t_state = 6'b000001;
    if (clear) begin
      case (state)
        T1: begin
          t_state = 6'b000001;
          pc_out  = 1'b1;
          mar_in  = 1'b1;
        end
        T2: begin
          t_state = 6'b000010;
          pc_inc  = 1'b1;
        end
        T3: begin
          t_state = 6'b000100;
          ram_out = 1'b1;
          ir_in   = 1'b1;
        end
        T4: begin
          t_state = 6'b001000;
          case (instruction)
            4'b0000, 4'b0001, 4'b0010: begin
              ir_out = 1'b1;
              mar_in = 1'b1;
            end
            4'b1110: begin
              acc_out = 1'b1;
              out_in  = 1'b1;
            end
`ifdef SAW_JMP_EN
            4'b0011: begin
              ir_out  = 1'b1;
              pc_load = 1'b1;
            end
`endif
            default: begin
              ir_out = 1'b0;
            end
          endcase
        end
        T5: begin
          t_state = 6'b010000;
          case (instruction)
            4'b0000: begin
              ram_out = 1'b1;
              acc_in  = 1'b1;
            end
            4'b0001: begin
              ram_out = 1'b1;
              b_in    = 1'b1;
            end
            4'b0010: begin
              ram_out = 1'b1;
              b_in    = 1'b1;
              sub     = 1'b1;
            end
            default: begin
              ram_out = 1'b0;
            end
          endcase
        end
        T6: begin
          t_state = 6'b100000;
          case (instruction)
            4'b0001: begin
              alu_out = 1'b1;
              acc_in  = 1'b1;
            end
            4'b0010: begin
              alu_out = 1'b1;
              acc_in  = 1'b1;
              sub     = 1'b1;
            end
            default: begin
              alu_out = 1'b0;
            end
          endcase
        end
        HALT: begin
          t_state = 6'b000000;
          halted  = 1'b1;
        end
        default: begin
          t_state = 6'b000000;
        end
      endcase
    end else begin
      t_state = 6'b000001;
    end
  end

endmodule
